// File: rtl/psg_bus_xfer_if.sv
// Signal bundle between the PSG bus transfer block, its requesters and the shared memory port.
// The transfer block uses the master view; a requester/memory side uses the slave view.
interface psg_bus_xfer_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [7:0]      sel;
    logic [2:0]      seln;
    logic [7:0]      req;
    logic [8*AW-1:0] req_adr;
    logic [8*DW-1:0] req_dat;
    logic [7:0]      req_we;
    logic            ack;
    logic            mem_cs;
    logic            mem_we;
    logic [AW-1:0]   mem_adr;
    logic [DW-1:0]   mem_dat_o;
    logic [DW-1:0]   mem_dat_i;
    logic [7:0]      done;
    logic [DW-1:0]   rdat;

    modport master (
        input  sel, seln, req, req_adr, req_dat, req_we, mem_dat_i,
        output ack, mem_cs, mem_we, mem_adr, mem_dat_o, done, rdat
    );

    modport slave (
        output sel, seln, req, req_adr, req_dat, req_we, mem_dat_i,
        input  ack, mem_cs, mem_we, mem_adr, mem_dat_o, done, rdat
    );
endinterface

// File: rtl/psg_bus_xfer.sv
// Runs one fixed-latency PSG memory access for the arbiter's current owner and
// reports completion and read data back to that requester.
module psg_bus_xfer #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    psg_bus_xfer_if.master bus
);
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_lat
        $error("psg_bus_xfer: RD_LAT must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, GRANT, ACCESS} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] owner;

    // The arbiter re-arbitrates on ce & ack, so ack must only be high between transfers.
    assign bus.ack = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            owner         <= '0;
            bus.mem_cs    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_adr   <= '0;
            bus.mem_dat_o <= '0;
            bus.done      <= '0;
            bus.rdat      <= '0;
        end else begin
            bus.mem_cs <= 1'b0;
            bus.done   <= '0;
            unique case (state)
                IDLE: begin
                    if (ce) state <= GRANT;
                end
                GRANT: begin
                    // seln alone picks the slice; sel only says whether any grant exists.
                    if (|bus.sel && bus.req[bus.seln]) begin
                        bus.mem_adr   <= bus.req_adr[int'(bus.seln)*AW +: AW];
                        bus.mem_dat_o <= bus.req_dat[int'(bus.seln)*DW +: DW];
                        bus.mem_we    <= bus.req_we[bus.seln];
                        bus.mem_cs    <= 1'b1;
                        owner         <= bus.seln;
                        cnt           <= 4'(RD_LAT);
                        state         <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!bus.mem_we) bus.rdat <= bus.mem_dat_i;
                        bus.done[owner] <= 1'b1;
                        bus.mem_we      <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psg_bus_xfer.sv
// Randomized bench for psg_bus_xfer: a timestamp-based transfer model predicts ack,
// mem_cs, done, rdat and the memory port for every cycle.
module tb_psg_bus_xfer;
    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int RD_LAT = 2;
    localparam int NEVER  = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce  = 1'b0;

    psg_bus_xfer_if #(.AW(AW), .DW(DW)) bus ();

    psg_bus_xfer #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .ce (ce),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, n);
        end
    endtask

    // Reference model: times of the pending grant, strobe, completion and bus-free cycle.
    int            grant_at, cs_at, done_at, free_at, last_cs, e_owner;
    int            last_owner = 7;
    logic [AW-1:0] e_adr, t_adr;
    logic [DW-1:0] e_dat, t_dat, e_rdat, rdat_next;
    logic          e_we;

    // Stimulus knobs
    int            ce_mode    = 0;
    bit            req_random = 0;
    bit            fixed_data = 1;
    bit            perturb    = 0;
    int            pert_idx   = -1;
    logic [7:0]    req_fix    = '0;
    logic [DW-1:0] mem_fix    = '0;

    task automatic reset_model();
        grant_at = -1; cs_at = -1; done_at = -1; free_at = n; last_cs = -1;
        e_adr = '0; e_dat = '0; e_we = 1'b0; e_rdat = '0; e_owner = 0;
    endtask

    task automatic check_outputs();
        if (n == cs_at) begin
            e_adr = t_adr;
            e_dat = t_dat;
        end
        if (n == done_at && !e_we) e_rdat = rdat_next;
        check("ack", 32'(bus.ack), 32'(n >= free_at));
        check("mem_cs", 32'(bus.mem_cs), 32'(n == cs_at));
        check("done", 32'(bus.done), (n == done_at) ? 32'(1 << e_owner) : 32'd0);
        check("rdat", 32'(bus.rdat), 32'(e_rdat));
        check("mem_adr", 32'(bus.mem_adr), 32'(e_adr));
        check("mem_dat_o", 32'(bus.mem_dat_o), 32'(e_dat));
        check("mem_we", 32'(bus.mem_we), (n >= cs_at && n < done_at) ? 32'(e_we) : 32'd0);
        if (bus.mem_cs === 1'b1) begin
            if (last_cs >= 0) check("cs_spacing", 32'(n - last_cs >= RD_LAT + 3), 32'd1);
            last_cs = n;
        end
    endtask

    task automatic drive_inputs();
        case (ce_mode)
            0:       ce = 1'b1;
            1:       ce = (n % 4 == 0);
            default: ce = 1'($urandom_range(0, 1));
        endcase
        bus.req = req_random ? 8'($urandom & $urandom) : req_fix;
        if (!fixed_data) begin
            for (int i = 0; i < 8; i++) begin
                bus.req_adr[i*AW +: AW] = AW'($urandom);
                bus.req_dat[i*DW +: DW] = DW'($urandom);
            end
            bus.req_we    = 8'($urandom);
            bus.mem_dat_i = DW'($urandom);
        end else begin
            bus.mem_dat_i = mem_fix;
        end

        if (n == grant_at) begin
            // Round-robin stand-in for the arbiter, presenting the new owner in the GRANT cycle.
            bus.sel  = '0;
            bus.seln = 3'($urandom);
            for (int k = 1; k <= 8; k++) begin
                int idx;
                idx = (last_owner + k) % 8;
                if (bus.req[idx]) begin
                    bus.sel    = 8'(1 << idx);
                    bus.seln   = 3'(idx);
                    last_owner = idx;
                    break;
                end
            end
            if (!fixed_data && $urandom_range(0, 7) == 0) bus.sel = bus.sel | 8'($urandom);
        end else if (perturb && cs_at >= 0 && n >= cs_at && n < done_at) begin
            int idx;
            idx = (pert_idx >= 0) ? pert_idx : int'($urandom_range(0, 7));
            bus.seln = 3'(idx);
            bus.sel  = 8'(1 << idx);
            if (pert_idx >= 0) req_fix = req_fix | 8'(1 << idx);
            bus.req = bus.req | 8'(1 << idx);
        end

        if (n == grant_at) begin
            if (bus.sel != 8'd0 && bus.req[bus.seln]) begin
                t_adr   = bus.req_adr[int'(bus.seln)*AW +: AW];
                t_dat   = bus.req_dat[int'(bus.seln)*DW +: DW];
                e_we    = bus.req_we[bus.seln];
                e_owner = int'(bus.seln);
                cs_at   = n + 1;
                done_at = n + 2 + RD_LAT;
                free_at = done_at;
            end else begin
                free_at = n + 1;
            end
            grant_at = -1;
        end else if (n >= free_at && ce) begin
            grant_at = n + 1;
            free_at  = NEVER;
        end
        if (n == done_at - 1) rdat_next = bus.mem_dat_i;
    endtask

    task automatic cycle(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            n++;
            check_outputs();
            drive_inputs();
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        n++;
        rst = 1'b1;
        reset_model();
        drive_inputs();
    endtask

    task automatic reset_mid_access();
        int guard;
        guard = 0;
        while (n != cs_at && guard < 50) begin
            cycle(1);
            guard++;
        end
        check("reset_wait_cs", 32'(n == cs_at), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rst_ack", 32'(bus.ack), 32'd1);
        check("rst_mem_cs", 32'(bus.mem_cs), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rdat", 32'(bus.rdat), 32'd0);
        check("rst_mem_adr", 32'(bus.mem_adr), 32'd0);
        @(negedge clk);
        n++;
        release_reset();
    endtask

    initial begin
        bus.sel = '0; bus.seln = '0; bus.req = '0;
        bus.req_adr = '0; bus.req_dat = '0; bus.req_we = '0; bus.mem_dat_i = '0;
        reset_model();
        repeat (2) @(negedge clk);

        // Read by requester 2
        req_fix = 8'h04; mem_fix = 16'hBEEF;
        bus.req_adr[2*AW +: AW] = 16'h1234;
        release_reset();
        cycle(12);

        // Write by requester 5; rdat must hold the earlier read value
        req_fix = 8'h20; bus.req_we = 8'h20; mem_fix = 16'h0F0F;
        bus.req_dat[5*DW +: DW] = 16'hA5A5;
        bus.req_adr[5*AW +: AW] = 16'h5555;
        cycle(12);

        // No requests with random ce: GRANT visited without any access
        req_fix = 8'h00; bus.req_we = '0; ce_mode = 2;
        cycle(20);

        // ce one cycle in four with requester 0 held
        req_fix = 8'h01; ce_mode = 1; mem_fix = 16'h0123;
        bus.req_adr[0*AW +: AW] = 16'h0A0A;
        cycle(40);

        // Owner changes to 6 while requester 1 is being served
        req_fix = 8'h02; ce_mode = 0; perturb = 1; pert_idx = 6;
        bus.req_adr[1*AW +: AW] = 16'h1111;
        bus.req_adr[6*AW +: AW] = 16'h6666;
        mem_fix = 16'h7E57;
        cycle(20);

        // Reset in the mem_cs cycle of a read by requester 3
        perturb = 0; req_fix = 8'h08; mem_fix = 16'hC0DE;
        bus.req_adr[3*AW +: AW] = 16'h3333;
        reset_mid_access();
        cycle(10);

        // Fully random traffic
        fixed_data = 0; req_random = 1; ce_mode = 2; perturb = 1; pert_idx = -1;
        cycle(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psg_bus_xfer.md
Name: psg_bus_xfer

Overview:
- Downstream companion to the PSG bus arbiter.
- Consumes the arbiter's one-hot grant and encoded owner, and muxes the owner's address, data and write-enable onto the shared PSG memory port.
- Runs a single fixed-latency access, then returns per-requester completion and read data.
- Drives the arbiter's `ack` input, which is high while the bus is free, so the arbiter re-arbitrates only between transfers.

Parameters:
- AW, 16: address width per requester.
- DW, 16: data width.
- RD_LAT, 2: cycles from the mem_cs cycle to valid mem_dat_i. Legal range 1..15; applies to reads and writes alike.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- ce  in  1  clock enable, same strobe the arbiter uses.
- sel  in  8  one-hot grant from arbiter (sel[i] = selN).
- seln  in  3  encoded owner from arbiter.
- req  in  8  request lines, the same ones fed to the arbiter.
- req_adr  in  8*AW  requester i address at [i*AW +: AW].
- req_dat  in  8*DW  requester i write data at [i*DW +: DW].
- req_we  in  8  requester i write enable.
- ack  out  1  to arbiter: bus free / transfer complete.
- mem_cs  out  1  memory access strobe, one cycle.
- mem_we  out  1  memory write enable.
- mem_adr  out  AW  memory address.
- mem_dat_o  out  DW  memory write data.
- mem_dat_i  in  DW  memory read data.
- done  out  8  one-cycle completion pulse to requester i.
- rdat  out  DW  captured read data.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, cnt = 0.
  - ack = 1; mem_cs, mem_we, mem_adr, mem_dat_o, done, rdat = 0.
  - Any in-flight access is abandoned and no done pulse is issued.
- States: IDLE, GRANT, ACCESS.
- ack is high in IDLE only, decoded from registered state.
- IDLE:
  - ack = 1.
  - ce = 0: stay in IDLE.
  - ce = 1: go to GRANT. The arbiter latches its new owner on this same edge because it sees ce & ack.
- GRANT (one cycle, ack = 0):
  - If |sel and req[seln]:
    - Register mem_adr, mem_dat_o, mem_we from slice seln.
    - mem_cs <= 1; latch owner index; cnt <= RD_LAT; go to ACCESS.
  - Otherwise (no owner, or the held owner has stopped requesting): go to IDLE with no memory access.
- ACCESS:
  - mem_cs is high for the first ACCESS cycle only.
  - mem_adr, mem_we and mem_dat_o are held stable for the whole state.
  - When cnt != 0: decrement cnt each cycle.
  - When cnt == 0:
    - If the latched mem_we is 0, rdat <= mem_dat_i; on writes rdat holds its value.
    - done[owner] <= 1 for exactly one cycle.
    - mem_we <= 0; go to IDLE.
- Latency:
  - With ce = 1 every cycle: IDLE->GRANT edge, then mem_cs high 1 cycle later.
  - done and ack rise RD_LAT+2 cycles after leaving IDLE.
  - done and new rdat appear in the same cycle ack returns to 1.
- Ownership:
  - The owner index is latched in GRANT. Changes on sel, seln or req during ACCESS are ignored.
  - ce is ignored outside IDLE.
- Requester contract:
  - A requester drops req on the cycle after it sees done.
  - If req is still high at the next arbitration, a new transfer is issued; this is legal and not an error.
- Non-one-hot sel: not checked. seln alone selects the slice; |sel gates validity.
- Back-to-back transfers: minimum spacing is RD_LAT+3 cycles between mem_cs pulses.
- done is one-hot or zero. A done pulse is never issued without a prior mem_cs.

Test Plan:
- Reset: drive rst low mid-ACCESS with mem_cs previously high -> ack = 1, mem_cs = 0, done = 0, rdat = 0 immediately. After release with ce = 1, the first mem_cs is 2 cycles after the first ce.
- Read: RD_LAT = 2, req2 = 1, req_adr slice 2 = 16'h1234, req_we[2] = 0, mem_dat_i = 16'hBEEF 2 cycles after mem_cs, ce = 1 -> mem_adr = 16'h1234, mem_cs high 1 cycle, done = 8'h04 and rdat = 16'hBEEF 4 cycles after the IDLE->GRANT edge, ack high in that same cycle.
- Write: req5 = 1, req_we[5] = 1, req_dat slice 5 = 16'hA5A5 -> mem_we = 1 and mem_dat_o = 16'hA5A5 through ACCESS; done = 8'h20; rdat unchanged.
- No request: all req = 0, ce pulses -> GRANT visited, ack drops for exactly 1 cycle, mem_cs never asserted, done stays 0.
- ce gating: ce = 1 one cycle in four, req0 held -> GRANT entered only after an IDLE cycle with ce = 1. ack stays high until a ce arrives. Transfers repeat, with mem_cs spacing >= RD_LAT+3.
- Owner change mid-access: during ACCESS for req1, switch seln to 6 and raise req6 -> mem_adr stays on requester 1 and done = 8'h02. Requester 6 is served in the next transfer.
